// File: rtl/sim_run_pkg.sv
// rtl/sim_run_pkg.sv - shared types for the simulation run-control monitor
// Holds run states, verdict reason codes and the reason priority order.
package sim_run_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } run_state_e;

  typedef enum logic [2:0] {
    RSN_NONE         = 3'd0,
    RSN_EXIT_NONZERO = 3'd1,
    RSN_TIMEOUT      = 3'd2,
    RSN_MISMATCH     = 3'd3,
    RSN_SKEW         = 3'd4
  } fail_reason_e;

  // Lower index wins when several checks fire in the same cycle.
  localparam int NUM_PRIO          = 4;
  localparam int PRIO_EXIT_NONZERO = 0;
  localparam int PRIO_MISMATCH     = 1;
  localparam int PRIO_SKEW         = 2;
  localparam int PRIO_TIMEOUT      = 3;

  function automatic fail_reason_e pick_reason(input logic [NUM_PRIO-1:0] i_hits);
    fail_reason_e w_r;
    w_r = RSN_NONE;
    if (i_hits[PRIO_TIMEOUT])      w_r = RSN_TIMEOUT;
    if (i_hits[PRIO_SKEW])         w_r = RSN_SKEW;
    if (i_hits[PRIO_MISMATCH])     w_r = RSN_MISMATCH;
    if (i_hits[PRIO_EXIT_NONZERO]) w_r = RSN_EXIT_NONZERO;
    return w_r;
  endfunction

endpackage

// File: rtl/sim_run_chan.sv
// rtl/sim_run_chan.sv - per-instance tohost exit latch
// Outputs show the latch as it will be after this cycle, so a write is visible immediately.
module sim_run_chan #(
  parameter int TOHOST_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [TOHOST_W-1:0] i_data,
  output logic                o_flag,
  output logic [TOHOST_W-2:0] o_code
);

  logic                r_done;
  logic [TOHOST_W-2:0] r_code;
  logic                w_take;

  assign w_take = i_en && i_valid && i_data[0] && !r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_done <= 1'b0;
      r_code <= '0;
    end else if (w_take) begin
      r_done <= 1'b1;
      r_code <= i_data[TOHOST_W-1:1];
    end
  end

  assign o_flag = r_done || w_take;
  assign o_code = w_take ? i_data[TOHOST_W-1:1] : r_code;

endmodule

// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - run-control monitor: cycle count, dump window, exit verdict
// Tracks exits of NUM_CH harness instances and produces a sticky pass/fail verdict.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 64,
  parameter int TOHOST_W = 64,
  parameter int SKEW_W   = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [CNT_W-1:0]                         cfg_max_cycles,
  input  logic [CNT_W-1:0]                         cfg_dump_start,
  input  logic [CNT_W-1:0]                         cfg_dump_len,
  input  logic [SKEW_W-1:0]                        cfg_skew_max,
  input  logic [NUM_CH-1:0]                        tohost_valid,
  input  logic [NUM_CH*TOHOST_W-1:0]               tohost_data,
  output logic [CNT_W-1:0]                         trace_count,
  output logic                                     dump_en,
  output logic                                     done,
  output logic                                     pass,
  output logic                                     fail,
  output logic [2:0]                               fail_reason,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
  output logic [TOHOST_W-2:0]                      exit_code
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CODE_W = TOHOST_W - 1;

  run_state_e          r_state;
  logic [CNT_W-1:0]    r_max, r_dstart, r_dlen, r_cnt;
  logic [SKEW_W-1:0]   r_skew_max, r_skew;
  logic                r_done, r_pass, r_fail;
  fail_reason_e        r_reason;
  logic [CH_W-1:0]     r_fail_ch;
  logic [CODE_W-1:0]   r_exit_code;

  logic [NUM_CH-1:0]   w_flag, w_nz, w_mm;
  logic [CODE_W-1:0]   w_code [NUM_CH];
  logic [CODE_W-1:0]   w_ref_code, w_exit_code;
  logic [CH_W-1:0]     w_nz_ch, w_mm_ch, w_sk_ch, w_fail_ch;
  logic                w_skew_hit, w_tmo_hit;
  logic [NUM_PRIO-1:0] w_hits;
  fail_reason_e        w_reason;
  logic [CNT_W:0]      w_dump_end;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    sim_run_chan #(.TOHOST_W(TOHOST_W)) u_chan (
      .clock   (clock),
      .reset   (reset),
      .i_en    (r_state != ST_DONE),
      .i_valid (tohost_valid[g]),
      .i_data  (tohost_data[g*TOHOST_W +: TOHOST_W]),
      .o_flag  (w_flag[g]),
      .o_code  (w_code[g])
    );
  end

  always_comb begin
    w_ref_code = '0;
    w_nz_ch    = '0;
    w_mm_ch    = '0;
    w_sk_ch    = '0;
    w_nz       = '0;
    w_mm       = '0;
    w_hits     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_flag[i]) w_ref_code = w_code[i];
    end
    // Mismatch is measured against the lowest-index channel that has exited.
    for (int i = 0; i < NUM_CH; i++) begin
      w_nz[i] = w_flag[i] && (w_code[i] != '0);
      w_mm[i] = (NUM_CH > 1) && w_flag[i] && (w_code[i] != w_ref_code);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_nz[i])    w_nz_ch = CH_W'(i);
      if (w_mm[i])    w_mm_ch = CH_W'(i);
      if (!w_flag[i]) w_sk_ch = CH_W'(i);
    end
    w_skew_hit = (NUM_CH > 1) && (r_state == ST_DRAIN) && (r_skew > r_skew_max);
    w_tmo_hit  = (r_max != '0) && (r_state != ST_DONE) && (r_cnt > r_max);
    w_hits[PRIO_EXIT_NONZERO] = |w_nz;
    w_hits[PRIO_MISMATCH]     = |w_mm;
    w_hits[PRIO_SKEW]         = w_skew_hit;
    w_hits[PRIO_TIMEOUT]      = w_tmo_hit;
    w_reason = pick_reason(w_hits);
    case (w_reason)
      RSN_EXIT_NONZERO: w_fail_ch = w_nz_ch;
      RSN_MISMATCH:     w_fail_ch = w_mm_ch;
      RSN_SKEW:         w_fail_ch = w_sk_ch;
      default:          w_fail_ch = '0;
    endcase
    w_exit_code = ((w_reason == RSN_EXIT_NONZERO) || (w_reason == RSN_MISMATCH))
                  ? w_code[w_fail_ch] : w_code[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_max       <= cfg_max_cycles;
      r_dstart    <= cfg_dump_start;
      r_dlen      <= cfg_dump_len;
      r_skew_max  <= cfg_skew_max;
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_skew      <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_reason    <= RSN_NONE;
      r_fail_ch   <= '0;
      r_exit_code <= '0;
    end else if (r_state != ST_DONE) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_RUN)  r_skew <= '0;
      else if (r_skew != '1)  r_skew <= r_skew + 1'b1;
      r_exit_code <= w_exit_code;
      if (w_reason != RSN_NONE) begin
        r_state   <= ST_DONE;
        r_done    <= 1'b1;
        r_fail    <= 1'b1;
        r_reason  <= w_reason;
        r_fail_ch <= w_fail_ch;
      end else if (&w_flag) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_pass  <= 1'b1;
      end else if (|w_flag) begin
        r_state <= ST_DRAIN;
      end
    end
  end

  // Window end is one bit wider so a start near all-ones cannot wrap.
  assign w_dump_end  = {1'b0, r_dstart} + {1'b0, r_dlen};
  assign dump_en     = !reset && (r_state != ST_DONE) && (r_cnt >= r_dstart)
                       && ((r_dlen == '0) || ({1'b0, r_cnt} < w_dump_end));
  assign trace_count = r_cnt;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_reason = r_reason;
  assign fail_ch     = r_fail_ch;
  assign exit_code   = r_exit_code;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb/tb_sim_run_ctrl.sv - bench for sim_run_ctrl with directed and random exit scenarios
module tb_sim_run_ctrl;

  localparam int NCH   = 2;
  localparam int TW    = 64;
  localparam int LIMIT = 400;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [63:0]         cfg_max_cycles, cfg_dump_start, cfg_dump_len;
  logic [15:0]         cfg_skew_max;
  logic [NCH-1:0]      tohost_valid;
  logic [NCH*TW-1:0]   tohost_data;
  logic [63:0]         trace_count;
  logic                dump_en, done, pass, fail;
  logic [2:0]          fail_reason;
  logic [0:0]          fail_ch;
  logic [62:0]         exit_code;

  int n_checks = 0;
  int n_errors = 0;

  int          ex [NCH];
  logic [62:0] cd [NCH];
  logic [63:0] s_max, s_dstart, s_dlen;
  logic [15:0] s_skew;
  int          abort_at;

  int          m_d, m_reason, m_ch;
  logic        m_found, m_pass;
  logic [62:0] m_code;

  sim_run_ctrl #(.NUM_CH(NCH), .CNT_W(64), .TOHOST_W(TW), .SKEW_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_max_cycles (cfg_max_cycles),
    .cfg_dump_start (cfg_dump_start),
    .cfg_dump_len   (cfg_dump_len),
    .cfg_skew_max   (cfg_skew_max),
    .tohost_valid   (tohost_valid),
    .tohost_data    (tohost_data),
    .trace_count    (trace_count),
    .dump_en        (dump_en),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .fail_reason    (fail_reason),
    .fail_ch        (fail_ch),
    .exit_code      (exit_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_window(input int k);
    logic [64:0] w_end;
    logic [63:0] kk;
    kk    = 64'(k);
    w_end = {1'b0, s_dstart} + {1'b0, s_dlen};
    return (kk >= s_dstart) && ((s_dlen == 64'd0) || ({1'b0, kk} < w_end));
  endfunction

  // Walks cycle numbers, applying the verdict rules to the set of channels exited so far.
  task automatic model_run();
    int first, nz_ch, mm_ch, sk_ch;
    logic [NCH-1:0] e;
    logic nz, mm, sk, tm;
    logic [62:0] refc;
    m_found = 1'b0; m_pass = 1'b0; m_reason = 0; m_ch = 0; m_code = '0; m_d = 0;
    first = -1;
    for (int i = 0; i < NCH; i++)
      if (ex[i] >= 0 && (first < 0 || ex[i] < first)) first = ex[i];
    for (int k = 0; k < LIMIT && !m_found; k++) begin
      nz = 1'b0; mm = 1'b0; nz_ch = 0; mm_ch = 0; sk_ch = 0; refc = '0;
      for (int i = 0; i < NCH; i++) e[i] = (ex[i] >= 0) && (ex[i] <= k);
      for (int i = NCH - 1; i >= 0; i--) begin
        if (e[i] && cd[i] != 0) begin nz = 1'b1; nz_ch = i; end
        if (e[i]) refc = cd[i];
        if (!e[i]) sk_ch = i;
      end
      for (int i = NCH - 1; i >= 0; i--)
        if (e[i] && cd[i] != refc) begin mm = 1'b1; mm_ch = i; end
      sk = (first >= 0) && (first < k) && ((k - first - 1) > int'(s_skew));
      tm = (s_max != 0) && (64'(k) > s_max);
      if (nz)      begin m_reason = 1; m_ch = nz_ch; end
      else if (mm) begin m_reason = 3; m_ch = mm_ch; end
      else if (sk) begin m_reason = 4; m_ch = sk_ch; end
      else if (tm) begin m_reason = 2; m_ch = 0;     end
      if (m_reason != 0 || &e) begin
        m_found = 1'b1;
        m_d     = k;
        m_pass  = (m_reason == 0);
        if (m_reason == 1 || m_reason == 3) m_code = cd[m_ch];
        else m_code = e[0] ? cd[0] : '0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b1;
    tohost_valid   = '0;
    tohost_data    = '0;
    cfg_max_cycles = s_max;
    cfg_dump_start = s_dstart;
    cfg_dump_len   = s_dlen;
    cfg_skew_max   = s_skew;
    repeat (2) @(negedge clock);
    check("rst_trace_count", trace_count, 64'd0);
    check("rst_dump_en", {63'd0, dump_en}, 64'd0);
    check("rst_done_pass_fail", {61'd0, done, pass, fail}, 64'd0);
    check("rst_fail_reason", {61'd0, fail_reason}, 64'd0);
    check("rst_fail_ch", {63'd0, fail_ch}, 64'd0);
    check("rst_exit_code", {1'b0, exit_code}, 64'd0);
    reset = 1'b0;
    cfg_max_cycles = 64'(s_max + 64'd3);
    #1;
  endtask

  task automatic run_scen();
    logic [63:0] exp_tc;
    logic        after;
    logic [62:0] rnd;
    model_run();
    do_reset();
    for (int k = 0; k < LIMIT; k++) begin
      if (k == abort_at) return;
      after  = m_found && (k > m_d);
      exp_tc = after ? 64'(m_d + 1) : 64'(k);
      check($sformatf("trace_count@%0d", k), trace_count, exp_tc);
      check($sformatf("dump_en@%0d", k), {63'd0, dump_en}, {63'd0, !after && in_window(k)});
      check($sformatf("done@%0d", k), {63'd0, done}, {63'd0, after});
      if (m_found && k == m_d + 1) begin
        check("verdict_pass", {63'd0, pass}, {63'd0, m_pass});
        check("verdict_fail", {63'd0, fail}, {63'd0, !m_pass});
        check("verdict_reason", {61'd0, fail_reason}, 64'(m_reason));
        check("verdict_fail_ch", {63'd0, fail_ch}, 64'(m_ch));
        check("verdict_exit_code", {1'b0, exit_code}, {1'b0, m_code});
      end
      if (m_found && k >= m_d + 3) return;
      for (int i = 0; i < NCH; i++) begin
        rnd = 63'({$urandom(), $urandom()});
        tohost_valid[i] = 1'b0;
        tohost_data[i*TW +: TW] = '0;
        if (ex[i] == k) begin
          tohost_valid[i] = 1'b1;
          tohost_data[i*TW +: TW] = {cd[i], 1'b1};
        end else if (ex[i] >= 0 && k == ex[i] + 1) begin
          tohost_valid[i] = 1'b1;
          tohost_data[i*TW +: TW] = {rnd, 1'b1};
        end else if ($urandom_range(3) == 0) begin
          tohost_valid[i] = 1'b1;
          tohost_data[i*TW +: TW] = {rnd, 1'b0};
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic set_scen(input int e0, input int e1, input logic [62:0] c0, input logic [62:0] c1,
                          input logic [63:0] mx, input logic [63:0] ds, input logic [63:0] dl,
                          input logic [15:0] sk, input int ab);
    ex[0] = e0; ex[1] = e1; cd[0] = c0; cd[1] = c1;
    s_max = mx; s_dstart = ds; s_dlen = dl; s_skew = sk; abort_at = ab;
    run_scen();
  endtask

  initial begin
    tohost_valid = '0;
    tohost_data  = '0;
    set_scen(100, 103, 0, 0, 0, 0, 0, 10, -1);
    set_scen(-1, 40, 0, 3, 0, 5, 20, 0, -1);
    set_scen(-1, -1, 0, 0, 50, 0, 0, 0, -1);
    set_scen(20, -1, 0, 0, 0, 3, 0, 5, -1);
    set_scen(15, 15, 0, 2, 0, 0, 0, 3, -1);
    set_scen(30, 31, 0, 0, 0, 10, 5, 3, -1);
    set_scen(-1, -1, 0, 0, 20, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, -1);
    set_scen(-1, -1, 0, 0, 100, 0, 0, 0, 30);
    set_scen(-1, -1, 0, 0, 40, 0, 0, 0, -1);
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NCH; i++) begin
        ex[i] = ($urandom_range(4) == 0) ? -1 : int'($urandom_range(60));
        cd[i] = ($urandom_range(3) == 0) ? 63'($urandom_range(7, 1)) : 63'd0;
      end
      s_max    = ($urandom_range(1) == 0) ? 64'd0 : 64'($urandom_range(120, 20));
      if (ex[0] < 0 && ex[1] < 0 && s_max == 0) s_max = 64'd70;
      s_dstart = 64'($urandom_range(40));
      s_dlen   = 64'($urandom_range(15));
      s_skew   = 16'($urandom_range(15));
      abort_at = ($urandom_range(7) == 0) ? int'($urandom_range(30, 1)) : -1;
      run_scen();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Synthesizable run-control monitor for the multi-instance simulation top. It replaces ad-hoc testbench termination logic with a parametrised block. It counts cycles and gates waveform dumping to a window. It tracks tohost exit writes from NUM_CH harness instances (main plus variants) and reports a single pass/fail verdict with a reason code. It also flags divergence between instances: mismatched exit codes, or completion skew beyond a limit.

Parameters:
NUM_CH, 2, number of harness instances monitored (1..8)
CNT_W, 64, cycle counter and config width
TOHOST_W, 64, tohost word width
SKEW_W, 16, width of completion-skew limit/counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; config latched on every cycle reset is high
cfg_max_cycles  in  CNT_W  timeout limit; 0 = no timeout
cfg_dump_start  in  CNT_W  first trace_count value with dump_en high
cfg_dump_len  in  CNT_W  dump window length; 0 = unbounded
cfg_skew_max  in  SKEW_W  max cycles between first and last channel exit
tohost_valid  in  NUM_CH  per-channel tohost write strobe
tohost_data  in  NUM_CH*TOHOST_W  per-channel write data, channel i at [i*TOHOST_W +: TOHOST_W]
trace_count  out  CNT_W  cycles since reset release
dump_en  out  1  waveform dump window active
done  out  1  verdict valid; sticky until reset
pass  out  1  all channels exited with code 0 and matching
fail  out  1  any failure
fail_reason  out  3  0 none, 1 exit_nonzero, 2 timeout, 3 mismatch, 4 skew
fail_ch  out  max(1,$clog2(NUM_CH))  lowest-index offending channel (0 for timeout)
exit_code  out  TOHOST_W-1  exit code of channel 0 (or fail_ch on exit_nonzero/mismatch)

Behaviour:
- Reset values: trace_count=0, dump_en=0, done=0, pass=0, fail=0, fail_reason=0, fail_ch=0, exit_code=0, all channel flags clear, state=RUN.
- Config is registered while reset=1. Config changes after release are ignored until the next reset.
- FSM states: RUN, DRAIN, DONE.
  - RUN -> DRAIN when the first channel exits. If all channels exit in the same cycle, go straight to DONE.
  - DRAIN -> DONE when all channels have exited, or on a failure.
  - Any state -> RUN on reset. Reset mid-run discards all state and re-latches config.
- trace_count increments by 1 each cycle in RUN/DRAIN, saturates at all-ones, and freezes in DONE. The first cycle after reset release shows 0; the next shows 1.
- Channel exit: tohost_valid[i] with data[0]=1 latches done_i and code_i=data[TOHOST_W-1:1]. Writes with data[0]=0 and any writes after the first exit are ignored.
- Failure checks, evaluated each cycle, registered into outputs the following cycle (verdict latency 1). Priority when several are true in one cycle: exit_nonzero > mismatch > skew > timeout.
  - exit_nonzero: a channel latches a nonzero code.
  - mismatch: two exited channels hold different codes.
  - skew: skew counter (starts at 0 on entering DRAIN, increments each DRAIN cycle, saturates) exceeds cfg_skew_max.
  - timeout: cfg_max_cycles != 0 and trace_count > cfg_max_cycles in RUN/DRAIN.
- pass=1 on entering DONE with all channels exited, all codes zero, and no failure. pass and fail are mutually exclusive. Exactly one of them is high whenever done=1.
- Once done=1, further tohost writes and counter events have no effect.
- dump_en=1 when not DONE and trace_count >= cfg_dump_start and (cfg_dump_len==0 or trace_count < cfg_dump_start+cfg_dump_len). The sum is computed in CNT_W+1 bits, so there is no wrap. cfg_dump_start=0 means dump_en is high from the first post-reset cycle.
- NUM_CH=1: mismatch and skew checks are disabled, and there is no DRAIN state.

Decomposition:
- Package sim_run_pkg holds:
  - the state enum (RUN/DRAIN/DONE);
  - the fail_reason enum with the encodings above;
  - the reason priority constants.
- Sub-module sim_run_chan, one instance per channel, holds the exit latch (done_i, code_i) and presents it as flag + code.
- Comparison, skew, timeout, FSM and dump logic stay in sim_run_ctrl.

Test Plan:
- NUM_CH=2, both channels write 0x1 at cycles 100 and 103, cfg_skew_max=10 -> done=1 one cycle after the second write, pass=1, fail_reason=0, trace_count frozen at 104.
- Channel 1 writes 0x7 (code 3) -> fail=1, fail_reason=1, fail_ch=1, exit_code=3, done=1 the next cycle even though channel 0 has not exited.
- cfg_max_cycles=50, no writes -> fail, fail_reason=2 when trace_count reaches 51; trace_count then holds; dump_en drops with done.
- Channel 0 exits at cycle 20, cfg_skew_max=5, channel 1 silent -> fail_reason=4 once the skew count is 6. In a second run, channel 0 writes 0x1 and channel 1 writes 0x5 in the same cycle -> fail_reason=1 wins over mismatch, fail_ch=1.
- cfg_dump_start=10, cfg_dump_len=5 -> dump_en high exactly while trace_count is 10..14. cfg_dump_start=all-ones, cfg_dump_len=2 -> no wrap, dump_en never glitches low early.
- Assert reset at cycle 30 of a run with a changed cfg_max_cycles -> all outputs return to reset values and the new limit is in effect. A tohost write with data[0]=0 has no effect.
